token_sampler: RTL and testbench

- Consumes the N-element Q1.15 probability stream from the softmax stage and draws one token index.
- Sampling is multinomial. An internal 32-bit LFSR supplies the random threshold; compiled-in greedy mode returns the argmax instead.
- Sits directly after softmax at the end of the logits path; the output index feeds the token embedding lookup for the next decode step.
- Buffers the N probabilities in one BRAM18, accumulating their sum and tracking the argmax during load, then performs one cumulative scan.

---
 rtl/token_sampler.sv | 236 +++++++++++++++++++++++
 tb/tb_token_sampler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/token_sampler.sv
// token_sampler: draws one token index from an N-element Q1.15 probability
// vector produced by the softmax stage.
//
// The vector is streamed into a single-port-style buffer. During the load the
// block sums the probabilities and, when greedy support is compiled in, tracks
// the argmax. Sampling is multinomial:
//   - A 32-bit Galois LFSR steps once.
//   - Its low 16 bits scale the sum into a threshold.
//   - One cumulative scan over the buffer picks the first index whose running
//     sum exceeds that threshold.
//
// Build option:
//   SAMPLER_GREEDY_EN - when defined, greedy_i is latched at start_i. A greedy
//                       vector returns the argmax (lowest index on ties) one
//                       cycle after its last beat, and the LFSR does not step.
//                       When undefined, greedy_i is ignored, the argmax logic
//                       is absent, and every vector is sampled.
//
// Handshake: in_ready_o is high for the whole load phase. A probability beat is
// consumed on every clock edge where in_ready_o and in_valid_i are both high.
// Upstream cannot be stalled, so gaps only come from in_valid_i going low.
// out_valid_o is a one-cycle pulse with no ready; out_token_o holds its value
// until the next pulse.

module token_sampler #(
   parameter int N   = 256,
   parameter int P_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  seed_valid_i,
   input  logic [31:0]           seed_i,
   input  logic                  greedy_i,
   input  logic                  in_valid_i,
   input  logic [P_W-1:0]        in_data_i,
   output logic                  in_ready_o,
   output logic                  out_valid_o,
   output logic [$clog2(N)-1:0]  out_token_o,
   output logic                  busy_o
);

   localparam int ADDR_W = $clog2(N);
   // The sum of N values of P_W bits each fits in ADDR_W+P_W bits.
   localparam int SUM_W  = ADDR_W + P_W;
   localparam int PROD_W = SUM_W + 16;

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N - 1);
   localparam logic [31:0]       LFSR_TAPS = 32'h80200003;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_THRESH = 3'd2,
      S_SCAN   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   cnt;        // next buffer slot to write
   logic [SUM_W-1:0]    sum_acc;    // sum of the loaded probabilities
   logic [SUM_W-1:0]    cum;        // running sum during the scan
   logic [SUM_W-1:0]    thr;        // random threshold, always below sum_acc
   logic [ADDR_W-1:0]   raddr;      // next buffer address to read in S_SCAN
   logic [ADDR_W-1:0]   idx;        // index of the element currently in rdata
   logic [31:0]         lfsr;
   logic                out_valid_q;
   logic [ADDR_W-1:0]   out_token_q;

   // Buffer storage. It has no reset so that it maps onto block RAM.
   logic [P_W-1:0]      mem [N];
   logic [P_W-1:0]      rdata;
   logic [ADDR_W-1:0]   rd_addr;

   logic                load_beat;
   logic [31:0]         lfsr_next;
   logic [PROD_W-1:0]   prod;
   logic [SUM_W-1:0]    thr_next;
   logic [SUM_W-1:0]    cum_next;

   assign load_beat = (state == S_LOAD) && in_valid_i;

   // Galois right-shift step of the LFSR.
   assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

   // thr = (sum_acc * r16) >> 16. Because r16 < 2^16, thr < sum_acc whenever
   // sum_acc is nonzero.
   assign prod     = PROD_W'(sum_acc) * PROD_W'(lfsr_next[15:0]);
   assign thr_next = prod[PROD_W-1:16];

   logic [15:0] unused_prod_lo;
   assign unused_prod_lo = prod[15:0];

   // The running sum includes the element returned by the buffer this cycle.
   assign cum_next = cum + SUM_W'(rdata);

   // S_THRESH reads address 0 so that element 0 is ready on the first S_SCAN
   // cycle. After that the scan streams one address per cycle.
   assign rd_addr = (state == S_SCAN) ? raddr : '0;

   // Buffer: written during load, read with one cycle of latency.
   always_ff @(posedge clk_i) begin
      if (load_beat) begin
         mem[cnt] <= in_data_i;
      end
      rdata <= mem[rd_addr];
   end

`ifdef SAMPLER_GREEDY_EN
   logic              greedy_q;
   logic [P_W-1:0]    max_val;
   logic [ADDR_W-1:0] max_idx;
   logic              beat_is_max;

   // The compare is strict, so the lowest index wins on equal maxima.
   assign beat_is_max = in_data_i > max_val;

   // Greedy mode is latched at start. The argmax is tracked over load beats.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         greedy_q <= 1'b0;
         max_val  <= '0;
         max_idx  <= '0;
      end else if ((state == S_IDLE) && start_i) begin
         greedy_q <= greedy_i;
         max_val  <= '0;
         max_idx  <= '0;
      end else if (load_beat && beat_is_max) begin
         max_val  <= in_data_i;
         max_idx  <= cnt;
      end
   end
`else
   logic unused_greedy;
   assign unused_greedy = greedy_i;
`endif

   // Control FSM. It owns the load counters, the LFSR, the scan, and the
   // registered result outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         cnt         <= '0;
         sum_acc     <= '0;
         cum         <= '0;
         thr         <= '0;
         raddr       <= '0;
         idx         <= '0;
         lfsr        <= 32'h1;
         out_valid_q <= 1'b0;
         out_token_q <= '0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               // A seed arriving with start is applied before the vector runs.
               if (seed_valid_i) begin
                  lfsr <= (seed_i == 32'h0) ? 32'h1 : seed_i;
               end
               if (start_i) begin
                  state   <= S_LOAD;
                  cnt     <= '0;
                  sum_acc <= '0;
               end
            end

            S_LOAD: begin
               if (in_valid_i) begin
                  sum_acc <= sum_acc + SUM_W'(in_data_i);
                  cnt     <= cnt + 1'b1;
                  if (cnt == LAST_IDX) begin
`ifdef SAMPLER_GREEDY_EN
                     if (greedy_q) begin
                        // The last beat may itself be the maximum.
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_token_q <= beat_is_max ? cnt : max_idx;
                     end else begin
                        state <= S_THRESH;
                     end
`else
                     state <= S_THRESH;
`endif
                  end
               end
            end

            S_THRESH: begin
               lfsr  <= lfsr_next;
               thr   <= thr_next;
               cum   <= '0;
               idx   <= '0;
               raddr <= ADDR_W'(1);
               if (sum_acc == '0) begin
                  state       <= S_DONE;
                  out_valid_q <= 1'b1;
                  out_token_q <= '0;
               end else begin
                  state <= S_SCAN;
               end
            end

            S_SCAN: begin
               cum   <= cum_next;
               idx   <= idx + 1'b1;
               raddr <= raddr + 1'b1;
               if (cum_next > thr) begin
                  state       <= S_DONE;
                  out_valid_q <= 1'b1;
                  out_token_q <= idx;
               end else if (idx == LAST_IDX) begin
                  // Fail-safe: the threshold is below the sum, so this branch
                  // should never be taken.
                  state       <= S_DONE;
                  out_valid_q <= 1'b1;
                  out_token_q <= LAST_IDX;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_o      = (state != S_IDLE);
   assign in_ready_o  = (state == S_LOAD);
   assign out_valid_o = out_valid_q;
   assign out_token_o = out_token_q;

endmodule

// File: tb/tb_token_sampler.sv
// Testbench for token_sampler. The reference model computes the sum, the
// threshold, and the cumulative pick directly from the probability array. It
// also steps its own copy of the LFSR once per sampled vector.

module tb_token_sampler;

   localparam int N      = 256;
   localparam int P_W    = 16;
   localparam int ADDR_W = $clog2(N);

   logic              clk;
   logic              rst_i;
   logic              start_i;
   logic              seed_valid_i;
   logic [31:0]       seed_i;
   logic              greedy_i;
   logic              in_valid_i;
   logic [P_W-1:0]    in_data_i;
   logic              in_ready_o;
   logic              out_valid_o;
   logic [ADDR_W-1:0] out_token_o;
   logic              busy_o;

   int                checks;
   int                errors;
   logic [31:0]       exp_q[$];
   logic [P_W-1:0]    vec [N];
   logic [31:0]       model_lfsr;

   token_sampler #(.N(N), .P_W(P_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .seed_valid_i (seed_valid_i),
      .seed_i       (seed_i),
      .greedy_i     (greedy_i),
      .in_valid_i   (in_valid_i),
      .in_data_i    (in_data_i),
      .in_ready_o   (in_ready_o),
      .out_valid_o  (out_valid_o),
      .out_token_o  (out_token_o),
      .busy_o       (busy_o)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      logic [31:0] t;
      t = s >> 1;
      if (s[0]) t = t ^ 32'h80200003;
      return t;
   endfunction

   function automatic longint vec_sum();
      longint s;
      s = 0;
      for (int i = 0; i < N; i++) s += vec[i];
      return s;
   endfunction

   // Multinomial pick: first index whose prefix sum strictly exceeds the threshold.
   function automatic int model_pick(input logic [31:0] r);
      longint sum;
      longint thr;
      longint cum;
      sum = vec_sum();
      if (sum == 0) return 0;
      thr = (sum * longint'(r[15:0])) >>> 16;
      cum = 0;
      for (int i = 0; i < N; i++) begin
         cum += vec[i];
         if (cum > thr) return i;
      end
      return N - 1;
   endfunction

   function automatic int model_argmax();
      int best;
      int bi;
      best = -1;
      bi   = 0;
      for (int i = 0; i < N; i++) begin
         if (int'(vec[i]) > best) begin
            best = vec[i];
            bi   = i;
         end
      end
      return bi;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic fill_zero();
      for (int i = 0; i < N; i++) vec[i] = '0;
   endtask

   task automatic fill_random(input int mode);
      for (int i = 0; i < N; i++) begin
         case (mode)
            0:       vec[i] = P_W'($urandom_range(0, 65535));
            1:       vec[i] = ($urandom_range(0, 9) == 0) ? P_W'($urandom_range(1, 65535)) : '0;
            default: vec[i] = P_W'($urandom_range(0, 3));
         endcase
      end
   endtask

   task automatic seed_load(input logic [31:0] s);
      @(posedge clk); #1;
      seed_valid_i = 1'b1;
      seed_i       = s;
      @(posedge clk); #1;
      seed_valid_i = 1'b0;
      model_lfsr   = (s == 32'h0) ? 32'h1 : s;
   endtask

   // Start a vector and stream vec[]. With gaps, idle cycles carry junk data
   // plus stray start/seed pulses that the busy block must ignore.
   task automatic load_vector(input bit greedy, input bit gaps);
      @(posedge clk); #1;
      start_i  = 1'b1;
      greedy_i = greedy;
      @(posedge clk); #1;
      start_i  = 1'b0;
      check("in_ready_after_start", 32'(in_ready_o), 32'd1);
      for (int i = 0; i < N; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
               in_valid_i   = 1'b0;
               in_data_i    = P_W'($urandom);
               start_i      = 1'($urandom_range(0, 1));
               seed_valid_i = 1'($urandom_range(0, 1));
               seed_i       = $urandom;
               @(posedge clk); #1;
            end
         end
         start_i      = 1'b0;
         seed_valid_i = 1'b0;
         in_valid_i   = 1'b1;
         in_data_i    = vec[i];
         @(posedge clk); #1;
      end
      in_valid_i = 1'b0;
      in_data_i  = '0;
   endtask

   // Wait for the result pulse. Latency is counted in cycles after the last beat.
   task automatic wait_result(output int tok, output int lat);
      logic [ADDR_W-1:0] held;
      lat = 1;
      tok = -1;
      while (lat <= N + 8 && out_valid_o !== 1'b1) begin
         @(posedge clk); #1;
         lat++;
      end
      if (out_valid_o === 1'b1) begin
         tok  = int'(out_token_o);
         held = out_token_o;
         @(posedge clk); #1;
         check("pulse_one_cycle", 32'(out_valid_o), 32'd0);
         check("idle_after_done", 32'(busy_o), 32'd0);
         check("token_holds", 32'(out_token_o), 32'(held));
      end else begin
         check("result_timeout", 32'(out_valid_o), 32'd1);
      end
   endtask

   // Full transaction scored against the model.
   task automatic run_and_check(input string tag, input bit greedy, input bit gaps,
                                output int tok);
      int     lat;
      int     exp_tok;
      int     exp_lat;
      logic [31:0] exp_w;
      bit     use_greedy;
`ifdef SAMPLER_GREEDY_EN
      use_greedy = greedy;
`else
      use_greedy = 1'b0;
`endif
      if (use_greedy) begin
         exp_tok = model_argmax();
         exp_lat = 1;
      end else begin
         model_lfsr = lfsr_step(model_lfsr);
         exp_tok    = model_pick(model_lfsr);
         exp_lat    = (vec_sum() == 0) ? 2 : 3 + exp_tok;
      end
      exp_q.push_back(32'(exp_tok));
      load_vector(greedy, gaps);
      wait_result(tok, lat);
      exp_w = exp_q.pop_front();
      check({tag, "_token"}, 32'(tok), exp_w);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int tok;
      int tok_a;
      int pulses;
      logic [31:0] s;

      checks       = 0;
      errors       = 0;
      rst_i        = 1'b1;
      start_i      = 1'b0;
      seed_valid_i = 1'b0;
      seed_i       = '0;
      greedy_i     = 1'b0;
      in_valid_i   = 1'b0;
      in_data_i    = '0;
      model_lfsr   = 32'h1;

      @(posedge clk); @(posedge clk); #1;
      check("rst_out_valid", 32'(out_valid_o), 32'd0);
      check("rst_out_token", 32'(out_token_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_in_ready", 32'(in_ready_o), 32'd0);
      rst_i = 1'b0;

      // LFSR comes out of reset as 1: r16 = 3, thr = 1, strict compare -> 11.
      fill_zero();
      vec[10] = 16'd1;
      vec[11] = 16'd32767;
      run_and_check("seed1_vec", 1'b0, 1'b0, tok);
      check("seed1_vec_spec_token", 32'(tok), 32'd11);

      // A zero seed is replaced by 1, so the same vector gives the same pick.
      seed_load(32'h0);
      run_and_check("seed0_vec", 1'b0, 1'b0, tok);
      check("seed0_vec_spec_token", 32'(tok), 32'd11);

      // One-hot at index 37 always wins, whatever the seed.
      fill_zero();
      vec[37] = 16'd32768;
      for (int v = 0; v < 20; v++) begin
         seed_load($urandom);
         run_and_check("onehot37", 1'b0, 1'b0, tok);
         check("onehot37_const", 32'(tok), 32'd37);
      end

      // All-zero vector: token 0 after 2 cycles.
      fill_zero();
      run_and_check("allzero", 1'b0, 1'b0, tok);

      // Random vectors of several densities with random seeds.
      for (int v = 0; v < 6; v++) begin
         seed_load($urandom);
         fill_random(v % 3);
         run_and_check("random", 1'b0, 1'b0, tok);
      end

      // A gapped load with stray start/seed pulses must match a gapless load.
      s = $urandom;
      fill_random(1);
      seed_load(s);
      run_and_check("gapless", 1'b0, 1'b0, tok_a);
      seed_load(s);
      run_and_check("gapped", 1'b0, 1'b1, tok);
      check("gapped_equals_gapless", 32'(tok), 32'(tok_a));

      // Reset in the middle of a long scan.
      seed_load($urandom);
      fill_zero();
      vec[200] = 16'd100;
      load_vector(1'b0, 1'b0);
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid_o === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      check("midscan_rst_busy", 32'(busy_o), 32'd0);
      check("midscan_rst_valid", 32'(out_valid_o), 32'd0);
      for (int c = 0; c < N + 4; c++) begin
         if (out_valid_o === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      check("midscan_no_pulse", 32'(pulses), 32'd0);
      model_lfsr = 32'h1;
      fill_random(0);
      run_and_check("after_rst", 1'b0, 1'b0, tok);

`ifdef SAMPLER_GREEDY_EN
      // Equal maxima: the lowest index wins, and the LFSR does not step.
      fill_zero();
      vec[5] = 16'd20000;
      vec[9] = 16'd20000;
      run_and_check("greedy_tie", 1'b1, 1'b0, tok);
      check("greedy_tie_const", 32'(tok), 32'd5);
      fill_random(0);
      run_and_check("greedy_rand", 1'b1, 1'b1, tok);
      fill_random(1);
      run_and_check("post_greedy_sampled", 1'b0, 1'b0, tok);
`else
      // Without greedy support, greedy_i is ignored and the vector is sampled.
      fill_random(0);
      run_and_check("greedy_ignored", 1'b1, 1'b0, tok);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog: the run always ends on its own.
   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

endmodule
